// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
interface dmem_access_unit_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wmask, dmem_wdata,
        input  dmem_resp, dmem_rdata
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wmask, dmem_wdata,
        output dmem_resp, dmem_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: issues one load/store per instruction,
// stalls the pipeline until the memory responds, flags misalignment/timeout.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic                       is_load,
    input  logic                       is_store,
    input  logic [2:0]                 funct3,
    input  logic [31:0]                alu_out,
    input  logic [31:0]                rs2_data,
    dmem_access_unit_if.master         dmem,
    output logic [31:0]                rdata_out,
    output logic [1:0]                 bit_shift,
    output logic                       stall,
    output logic                       done,
    output logic                       misalign_err,
    output logic                       timeout_err
);

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          mem_op, do_store, misaligned, timeout_hit;
    logic [3:0]    store_mask;
    logic [31:0]   store_wdata;
    logic [CW-1:0] busy_cnt;
    logic          rd_q, wr_q, mis_q, to_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [3:0]    wmask_q;
    logic [1:0]    bs_q;

    // A simultaneous load+store is treated as a load.
    assign mem_op      = req_valid && (is_load || is_store);
    assign do_store    = is_store && !is_load;
    assign timeout_hit = TIMEOUT_EN && (busy_cnt == CNT_LAST);

    // Decode access size into byte enables, lane-replicated data and alignment.
    always_comb begin
        store_mask  = 4'b1111;
        store_wdata = rs2_data;
        misaligned  = (alu_out[1:0] != 2'b00);
        case (funct3)
            3'b000, 3'b100: begin
                store_mask  = 4'b0001 << alu_out[1:0];
                store_wdata = {4{rs2_data[7:0]}};
                misaligned  = 1'b0;
            end
            3'b001, 3'b101: begin
                store_mask  = 4'b0011 << {alu_out[1], 1'b0};
                store_wdata = {2{rs2_data[15:0]}};
                misaligned  = alu_out[0];
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; DONE always returns to IDLE so no request is accepted in it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = misaligned ? DONE : BUSY;
            BUSY:    if (dmem.dmem_resp || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request, capture and error-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wmask_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            bs_q     <= '0;
            busy_cnt <= '0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_op) begin
                    mis_q <= misaligned;
                    to_q  <= 1'b0;
                    if (misaligned) begin
                        rdata_q <= '0;
                    end else begin
                        rd_q     <= !do_store;
                        wr_q     <= do_store;
                        addr_q   <= {alu_out[31:2], 2'b00};
                        wmask_q  <= do_store ? store_mask : 4'b0000;
                        wdata_q  <= store_wdata;
                        bs_q     <= alu_out[1:0];
                        busy_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_resp) begin
                        rd_q <= 1'b0;
                        wr_q <= 1'b0;
                        if (rd_q) rdata_q <= dmem.dmem_rdata;
                    end else if (timeout_hit) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        rdata_q <= '0;
                        to_q    <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from state; error flags only visible with done.
    always_comb begin
        stall        = 1'b0;
        done         = 1'b0;
        misalign_err = 1'b0;
        timeout_err  = 1'b0;
        case (state)
            IDLE: stall = mem_op;
            BUSY: stall = 1'b1;
            DONE: begin
                done         = 1'b1;
                misalign_err = mis_q;
                timeout_err  = to_q;
            end
            default: ;
        endcase
    end

    assign dmem.dmem_read    = rd_q;
    assign dmem.dmem_write   = wr_q;
    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_wmask   = wmask_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign rdata_out         = rdata_q;
    assign bit_shift         = bs_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized self-checking bench for dmem_access_unit with a transaction-level model.
module tb_dmem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_out, rs2_data;
    logic [31:0] rdata_out;
    logic [1:0]  bit_shift;
    logic        stall, done, misalign_err, timeout_err;

    dmem_access_unit_if dmem_bus();

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .is_load      (is_load),
        .is_store     (is_store),
        .funct3       (funct3),
        .alu_out      (alu_out),
        .rs2_data     (rs2_data),
        .dmem         (dmem_bus),
        .rdata_out    (rdata_out),
        .bit_shift    (bit_shift),
        .stall        (stall),
        .done         (done),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_bs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One MEM-stage instruction; lat = BUSY cycle carrying dmem_resp (0 = never).
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input int unsigned lat, input logic [31:0] rd);
        logic        st_eff;
        int unsigned size, off;
        logic        mis, exp_to;
        logic [3:0]  mask;
        logic [31:0] wd, src;
        logic [2:0]  f3v;
        st_eff = st && !ld;
        f3v    = f3;
        size   = 1 << f3v[1:0];
        off    = addr % 4;
        mis    = (addr % size) != 0;
        mask   = st_eff ? 4'(((1 << size) - 1) << off) : 4'b0000;
        src    = rs2;
        wd     = '0;
        for (int unsigned i = 0; i < 4; i++) wd[8*i +: 8] = src[8*(i % size) +: 8];
        exp_to = 1'b0;

        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        alu_out = addr; rs2_data = rs2;
        dmem_bus.dmem_resp  = 1'($urandom % 2);
        dmem_bus.dmem_rdata = $urandom;
        #1;
        check_eq("req_stall", stall, 1);
        check_eq("req_done", done, 0);
        check_eq("req_rd", dmem_bus.dmem_read, 0);
        check_eq("req_wr", dmem_bus.dmem_write, 0);
        step();
        dmem_bus.dmem_resp = 1'b0;

        if (!mis) begin
            for (int unsigned k = 1; k <= TO; k++) begin
                check_eq("busy_stall", stall, 1);
                check_eq("busy_done", done, 0);
                check_eq("busy_rd", dmem_bus.dmem_read, ld);
                check_eq("busy_wr", dmem_bus.dmem_write, st_eff);
                check_eq("busy_addr", dmem_bus.dmem_address, addr - off);
                check_eq("busy_wmask", dmem_bus.dmem_wmask, mask);
                if (st_eff) check_eq("busy_wdata", dmem_bus.dmem_wdata, wd);
                if (k == lat) begin
                    dmem_bus.dmem_resp  = 1'b1;
                    dmem_bus.dmem_rdata = rd;
                end
                step();
                dmem_bus.dmem_resp = 1'b0;
                if (k == lat) break;
            end
            exp_bs = addr[1:0];
            if (lat >= 1 && lat <= TO) begin
                if (ld) exp_rdata = rd;
            end else begin
                exp_rdata = '0;
                exp_to    = 1'b1;
            end
        end else begin
            exp_rdata = '0;
        end

        check_eq("done_done", done, 1);
        check_eq("done_stall", stall, 0);
        check_eq("done_mis", misalign_err, mis);
        check_eq("done_to", timeout_err, exp_to);
        check_eq("done_rd", dmem_bus.dmem_read, 0);
        check_eq("done_wr", dmem_bus.dmem_write, 0);
        check_eq("done_rdata", rdata_out, exp_rdata);
        check_eq("done_bs", bit_shift, exp_bs);
        dmem_bus.dmem_resp = 1'($urandom % 2);
        step();
        dmem_bus.dmem_resp = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("post_done", done, 0);
        check_eq("post_stall", stall, 0);
        check_eq("post_rd", dmem_bus.dmem_read, 0);
        check_eq("post_wr", dmem_bus.dmem_write, 0);
    endtask

    // Non-memory instruction (or idle slot): no stall, no bus activity.
    task automatic run_nop(input logic rv);
        req_valid = rv; is_load = rv ? 1'b0 : 1'($urandom % 2); is_store = 1'b0;
        funct3 = 3'($urandom); alu_out = $urandom; rs2_data = $urandom;
        dmem_bus.dmem_resp  = 1'($urandom % 2);
        dmem_bus.dmem_rdata = $urandom;
        #1;
        check_eq("nop_stall", stall, 0);
        check_eq("nop_done", done, 0);
        check_eq("nop_rd", dmem_bus.dmem_read, 0);
        check_eq("nop_wr", dmem_bus.dmem_write, 0);
        step();
        dmem_bus.dmem_resp = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("nop_done2", done, 0);
        check_eq("nop_rd2", dmem_bus.dmem_read, 0);
        check_eq("nop_rdata", rdata_out, exp_rdata);
        check_eq("nop_bs", bit_shift, exp_bs);
    endtask

    // Reset during the second BUSY cycle, then a stray response.
    task automatic run_reset_abort();
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        alu_out = 32'h0000_0044; rs2_data = '0; dmem_bus.dmem_resp = 1'b0;
        step();
        step();
        check_eq("ra_busy_rd", dmem_bus.dmem_read, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 1'b0;
        exp_rdata = '0; exp_bs = '0;
        dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        #1;
        check_eq("ra_rd", dmem_bus.dmem_read, 0);
        check_eq("ra_addr", dmem_bus.dmem_address, 0);
        check_eq("ra_wmask", dmem_bus.dmem_wmask, 0);
        check_eq("ra_stall", stall, 0);
        check_eq("ra_rdata", rdata_out, 0);
        check_eq("ra_bs", bit_shift, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            dmem_bus.dmem_resp = 1'b0;
            check_eq("ra_done", done, 0);
            check_eq("ra_rdata2", rdata_out, 0);
        end
    endtask

    initial begin
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; alu_out = '0; rs2_data = '0;
        dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        exp_rdata = '0; exp_bs = '0;
        check_eq("rst_rd", dmem_bus.dmem_read, 0);
        check_eq("rst_wr", dmem_bus.dmem_write, 0);
        check_eq("rst_addr", dmem_bus.dmem_address, 0);
        check_eq("rst_wmask", dmem_bus.dmem_wmask, 0);
        check_eq("rst_wdata", dmem_bus.dmem_wdata, 0);
        check_eq("rst_rdata", rdata_out, 0);
        check_eq("rst_bs", bit_shift, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_stall", stall, 0);

        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 3, 32'h0);
        run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h1234_5678, 1, 32'h0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0084, 32'h0, TO, 32'h1234_5678);
        run_txn(1'b1, 1'b1, 3'b001, 32'h0000_0106, 32'hFFFF_FFFF, 2, 32'h5555_AAAA);
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hFEED_0001, 0, 32'h0);
        run_nop(1'b1);
        run_nop(1'b0);
        run_reset_abort();

        for (int n = 0; n < 200; n++) begin
            if ($urandom % 4 == 0) begin
                run_nop(1'($urandom % 2));
            end else begin
                ld = 1'($urandom % 2);
                st = 1'($urandom % 2);
                if (!ld && !st) ld = 1'b1;
                f3 = ld ? ld_f3[$urandom % 5] : 3'($urandom % 3);
                addr = $urandom;
                if ($urandom % 2 == 0) addr[1:0] = 2'b00;
                run_txn(ld, st, f3, addr, $urandom, $urandom_range(0, 5), $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
